lsu_agu: RTL and testbench

- Load/store address-generation stage that sits directly upstream of the data memory stage.
- Accepts decoded load/store micro-ops from the load/store reservation station and computes the effective address EA = (RA|0) + B.
- Produces the byte-lane read/write enables and the left-justified store data in the format the data memory stage consumes.
- For update-form instructions (lwzu, stbux, ...) it also emits an EA writeback to RA on a separate result channel.

---
 rtl/lsu_agu.sv | 79 +++++++
 tb/tb_lsu_agu.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_agu.sv
// lsu_agu: load/store effective-address generation feeding a data-memory request
// register and an independent EA-writeback register for update-form ops.
module lsu_agu #(
    parameter int RS_ID_WIDTH = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [4:0]             update_reg_addr_in,
    input  logic [31:0]            op_a,
    input  logic                   op_a_zero,
    input  logic [31:0]            op_b,
    input  logic                   is_store,
    input  logic [1:0]             size,
    input  logic                   update,
    input  logic [31:0]            store_data,
    output logic                   mem_valid,
    input  logic                   mem_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [31:0]            mem_address,
    output logic [3:0]             mem_write_en,
    output logic [31:0]            mem_write_data,
    output logic [3:0]             mem_read_en,
    output logic                   upd_valid,
    input  logic                   upd_ready,
    output logic [RS_ID_WIDTH-1:0] upd_rs_id,
    output logic [4:0]             upd_reg_addr,
    output logic [31:0]            upd_data
);
    logic        accept;
    logic        reserved;
    logic [31:0] ea;
    logic [31:0] wdata;
    logic [3:0]  mask;
    always_comb begin
        input_ready = (~mem_valid | mem_ready) & (~upd_valid | upd_ready);
        accept      = input_valid & input_ready;
        reserved    = size == 2'b11;
        ea          = (op_a_zero ? 32'd0 : op_a) + op_b;
        mask        = size == 2'b00 ? 4'b1000 : size == 2'b01 ? 4'b1100 : size == 2'b10 ? 4'b1111 : 4'b0000;
        wdata       = size == 2'b00 ? {store_data[7:0], 24'd0} :
                      size == 2'b01 ? {store_data[15:0], 16'd0} : store_data;
    end
    // Payload only moves on accept, which already implies both channels are free or draining.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid           <= 1'b0;
            upd_valid           <= 1'b0;
            rs_id_out           <= '0;
            result_reg_addr_out <= '0;
            mem_address         <= '0;
            mem_write_en        <= '0;
            mem_write_data      <= '0;
            mem_read_en         <= '0;
            upd_rs_id           <= '0;
            upd_reg_addr        <= '0;
            upd_data            <= '0;
        end else if (accept) begin
            mem_valid           <= ~reserved;
            upd_valid           <= update & ~reserved;
            rs_id_out           <= rs_id_in;
            result_reg_addr_out <= result_reg_addr_in;
            mem_address         <= ea;
            mem_write_en        <= is_store ? mask : 4'b0000;
            mem_write_data      <= wdata;
            mem_read_en         <= is_store ? 4'b0000 : mask;
            upd_rs_id           <= rs_id_in;
            upd_reg_addr        <= update_reg_addr_in;
            upd_data            <= ea;
        end else begin
            if (mem_ready) mem_valid <= 1'b0;
            if (upd_ready) upd_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_agu.sv
// tb_lsu_agu: directed scenarios plus a randomized run scored against queue-based expectations.
module tb_lsu_agu;
    localparam int W = 7;
    logic clk = 0, rst = 1;
    logic input_valid = 0, input_ready;
    logic [W-1:0] rs_id_in = 0, rs_id_out, upd_rs_id;
    logic [4:0] result_reg_addr_in = 0, update_reg_addr_in = 0, result_reg_addr_out, upd_reg_addr;
    logic [31:0] op_a = 0, op_b = 0, store_data = 0, mem_address, mem_write_data, upd_data;
    logic op_a_zero = 0, is_store = 0, update = 0, mem_ready = 1, upd_ready = 1, mem_valid, upd_valid;
    logic [1:0] size = 2'b10;
    logic [3:0] mem_write_en, mem_read_en;
    int n_checks = 0, n_fail = 0;

    typedef struct {
        logic [W-1:0] id;
        logic [4:0]   rt;
        logic [31:0]  addr;
        logic [3:0]   we;
        logic [3:0]   re;
        logic [31:0]  wd;
        logic         st;
    } mem_t;
    typedef struct {
        logic [W-1:0] id;
        logic [4:0]   ra;
        logic [31:0]  data;
    } upd_t;
    mem_t mq[$];
    upd_t uq[$];

    lsu_agu #(.RS_ID_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .input_valid(input_valid), .input_ready(input_ready),
        .rs_id_in(rs_id_in), .result_reg_addr_in(result_reg_addr_in),
        .update_reg_addr_in(update_reg_addr_in), .op_a(op_a), .op_a_zero(op_a_zero),
        .op_b(op_b), .is_store(is_store), .size(size), .update(update),
        .store_data(store_data), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .rs_id_out(rs_id_out), .result_reg_addr_out(result_reg_addr_out),
        .mem_address(mem_address), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_en(mem_read_en),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_rs_id(upd_rs_id),
        .upd_reg_addr(upd_reg_addr), .upd_data(upd_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [W-1:0] id, input logic [31:0] a, input logic az,
                          input logic [31:0] b, input logic st, input logic [1:0] sz,
                          input logic up, input logic [31:0] sd);
        input_valid = 1; rs_id_in = id; op_a = a; op_a_zero = az; op_b = b;
        is_store = st; size = sz; update = up; store_data = sd;
        result_reg_addr_in = id[4:0]; update_reg_addr_in = ~id[4:0];
    endtask

    function automatic mem_t model_mem();
        int nb = 1 << size;
        mem_t m;
        m.id = rs_id_in; m.rt = result_reg_addr_in; m.st = is_store;
        m.addr = (op_a_zero ? 32'd0 : op_a) + op_b;
        m.we = is_store ? 4'(((1 << nb) - 1) << (4 - nb)) : 4'd0;
        m.re = is_store ? 4'd0 : 4'(((1 << nb) - 1) << (4 - nb));
        m.wd = store_data << (8 * (4 - nb));
        return m;
    endfunction

    task automatic test_reset();
        rst = 1; input_valid = 0;
        step(); step();
        rst = 0;
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: got %b want 0", mem_valid); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_upd_valid: got %b want 0", upd_valid); end
        n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL reset_input_ready: got %b want 1", input_ready); end
        n_checks++; if ({mem_address, upd_data, mem_write_data} !== 96'd0) begin n_fail++; $display("FAIL reset_payload: got %h %h %h want 0", mem_address, upd_data, mem_write_data); end
        n_checks++; if ({mem_write_en, mem_read_en, rs_id_out, upd_rs_id, result_reg_addr_out, upd_reg_addr} !== '0) begin n_fail++; $display("FAIL reset_tags: got nonzero, want 0"); end
    endtask

    task automatic test_load_word();
        mem_ready = 1; upd_ready = 1;
        set_op(7'd3, 32'h1000, 0, 32'h4, 0, 2'b10, 0, 32'h0);
        #1;
        n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL lw_ready: got %b want 1", input_ready); end
        step(); input_valid = 0; #1;
        n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL lw_mem_valid: got %b want 1", mem_valid); end
        n_checks++; if (mem_address !== 32'h1004) begin n_fail++; $display("FAIL lw_addr: got %h want 00001004", mem_address); end
        n_checks++; if (mem_read_en !== 4'b1111) begin n_fail++; $display("FAIL lw_read_en: got %b want 1111", mem_read_en); end
        n_checks++; if (mem_write_en !== 4'b0000) begin n_fail++; $display("FAIL lw_write_en: got %b want 0000", mem_write_en); end
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL lw_upd_valid: got %b want 0", upd_valid); end
        n_checks++; if (rs_id_out !== 7'd3) begin n_fail++; $display("FAIL lw_rs_id: got %0d want 3", rs_id_out); end
        step(); #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL lw_drain: got %b want 0", mem_valid); end
    endtask

    task automatic test_store_byte();
        set_op(7'd9, 32'hFFFF, 1, 32'h103, 1, 2'b00, 0, 32'h1122_33AB);
        step(); input_valid = 0; #1;
        n_checks++; if (mem_address !== 32'h103) begin n_fail++; $display("FAIL stb_addr: got %h want 00000103", mem_address); end
        n_checks++; if (mem_write_en !== 4'b1000) begin n_fail++; $display("FAIL stb_write_en: got %b want 1000", mem_write_en); end
        n_checks++; if (mem_read_en !== 4'b0000) begin n_fail++; $display("FAIL stb_read_en: got %b want 0000", mem_read_en); end
        n_checks++; if (mem_write_data !== 32'hAB00_0000) begin n_fail++; $display("FAIL stb_data: got %h want ab000000", mem_write_data); end
        step();
    endtask

    task automatic test_update_half();
        mem_ready = 1; upd_ready = 0;
        set_op(7'd21, 32'h2000, 0, 32'hFFFF_FFFE, 1, 2'b01, 1, 32'h0000_BEEF);
        step(); input_valid = 0; #1;
        n_checks++; if (mem_valid !== 1'b1 || mem_write_en !== 4'b1100) begin n_fail++; $display("FAIL sthu_mem: got valid=%b we=%b want 1 1100", mem_valid, mem_write_en); end
        n_checks++; if (mem_write_data !== 32'hBEEF_0000) begin n_fail++; $display("FAIL sthu_data: got %h want beef0000", mem_write_data); end
        for (int c = 1; c <= 3; c++) begin
            n_checks++; if (upd_valid !== 1'b1 || upd_data !== 32'h1FFE) begin n_fail++; $display("FAIL sthu_upd_c%0d: got valid=%b data=%h want 1 00001ffe", c, upd_valid, upd_data); end
            n_checks++; if (upd_reg_addr !== ~5'd21 || upd_rs_id !== 7'd21) begin n_fail++; $display("FAIL sthu_upd_tag_c%0d: got ra=%0d id=%0d", c, upd_reg_addr, upd_rs_id); end
            n_checks++; if (input_ready !== 1'b0) begin n_fail++; $display("FAIL sthu_ready_c%0d: got %b want 0", c, input_ready); end
            if (c > 1) begin
                n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL sthu_mem_done_c%0d: got %b want 0", c, mem_valid); end
            end
            step();
        end
        upd_ready = 1; #1;
        n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL sthu_ready_release: got %b want 1", input_ready); end
        step(); #1;
        n_checks++; if (upd_valid !== 1'b0) begin n_fail++; $display("FAIL sthu_upd_drain: got %b want 0", upd_valid); end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1; upd_ready = 1;
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) set_op(7'(40 + k), 32'h4000, 0, 32'(k * 16), 0, 2'b10, 0, 32'h0);
            else input_valid = 0;
            #1;
            n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want 1", k, input_ready); end
            if (k > 0) begin
                n_checks++; if (mem_valid !== 1'b1 || rs_id_out !== 7'(39 + k) || mem_address !== 32'h4000 + 32'((k - 1) * 16))
                begin n_fail++; $display("FAIL b2b_req_%0d: got v=%b id=%0d a=%h want 1 %0d %h", k, mem_valid, rs_id_out, mem_address, 39 + k, 32'h4000 + 32'((k - 1) * 16)); end
            end
            step();
        end
    endtask

    task automatic test_wrap();
        set_op(7'd5, 32'hFFFF_FFFC, 0, 32'h8, 0, 2'b10, 1, 32'h0);
        step(); input_valid = 0; #1;
        n_checks++; if (mem_address !== 32'h4) begin n_fail++; $display("FAIL wrap_addr: got %h want 00000004", mem_address); end
        n_checks++; if (upd_valid !== 1'b1 || upd_data !== 32'h4) begin n_fail++; $display("FAIL wrap_upd: got v=%b d=%h want 1 00000004", upd_valid, upd_data); end
        step();
    endtask

    task automatic test_reserved_reset();
        mem_ready = 1; upd_ready = 1;
        set_op(7'd7, 32'h10, 0, 32'h20, 1, 2'b11, 1, 32'h55);
        #1;
        n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL rsv_ready: got %b want 1", input_ready); end
        step(); input_valid = 0; #1;
        n_checks++; if (mem_valid !== 1'b0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL rsv_valids: got %b %b want 0 0", mem_valid, upd_valid); end
        mem_ready = 0;
        set_op(7'd8, 32'h300, 0, 32'h4, 0, 2'b10, 1, 32'h0);
        step(); input_valid = 0; #1;
        n_checks++; if (mem_valid !== 1'b1 || input_ready !== 1'b0) begin n_fail++; $display("FAIL rsv_pending: got v=%b rdy=%b want 1 0", mem_valid, input_ready); end
        rst = 1;
        step(); rst = 0; #1;
        n_checks++; if (mem_valid !== 1'b0 || upd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valids: got %b %b want 0 0", mem_valid, upd_valid); end
        n_checks++; if ({mem_address, upd_data, rs_id_out, mem_read_en} !== '0) begin n_fail++; $display("FAIL rst_mid_payload: got %h %h %0d %b want 0", mem_address, upd_data, rs_id_out, mem_read_en); end
        n_checks++; if (input_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", input_ready); end
        mem_ready = 1;
    endtask

    task automatic test_random();
        mem_t m;
        upd_t u;
        logic exp_ready;
        mq.delete(); uq.delete();
        for (int c = 0; c < 400; c++) begin
            set_op(7'($urandom), $urandom, ($urandom % 4) == 0, $urandom, $urandom % 2,
                   2'($urandom), $urandom % 2, $urandom);
            input_valid = ($urandom % 4) != 0;
            mem_ready = ($urandom % 3) != 0;
            upd_ready = ($urandom % 3) != 0;
            #1;
            exp_ready = (mq.size() == 0 || mem_ready) && (uq.size() == 0 || upd_ready);
            n_checks++; if (input_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, input_ready, exp_ready); end
            n_checks++; if (mem_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_mem_valid c%0d: got %b want %b", c, mem_valid, mq.size() != 0); end
            n_checks++; if (upd_valid !== (uq.size() != 0)) begin n_fail++; $display("FAIL rnd_upd_valid c%0d: got %b want %b", c, upd_valid, uq.size() != 0); end
            if (mq.size() != 0) begin
                m = mq[0];
                n_checks++; if (mem_address !== m.addr || rs_id_out !== m.id || result_reg_addr_out !== m.rt)
                begin n_fail++; $display("FAIL rnd_mem_hdr c%0d: got a=%h id=%0d rt=%0d want %h %0d %0d", c, mem_address, rs_id_out, result_reg_addr_out, m.addr, m.id, m.rt); end
                n_checks++; if (mem_write_en !== m.we || mem_read_en !== m.re) begin n_fail++; $display("FAIL rnd_mem_mask c%0d: got we=%b re=%b want %b %b", c, mem_write_en, mem_read_en, m.we, m.re); end
                if (m.st) begin
                    n_checks++; if (mem_write_data !== m.wd) begin n_fail++; $display("FAIL rnd_mem_wd c%0d: got %h want %h", c, mem_write_data, m.wd); end
                end
                if (mem_ready) void'(mq.pop_front());
            end
            if (uq.size() != 0) begin
                u = uq[0];
                n_checks++; if (upd_data !== u.data || upd_rs_id !== u.id || upd_reg_addr !== u.ra)
                begin n_fail++; $display("FAIL rnd_upd c%0d: got d=%h id=%0d ra=%0d want %h %0d %0d", c, upd_data, upd_rs_id, upd_reg_addr, u.data, u.id, u.ra); end
                if (upd_ready) void'(uq.pop_front());
            end
            if (input_valid && exp_ready && size != 2'b11) begin
                m = model_mem();
                mq.push_back(m);
                if (update) begin
                    u.id = rs_id_in; u.ra = update_reg_addr_in; u.data = m.addr;
                    uq.push_back(u);
                end
            end
            step();
        end
        input_valid = 0; mem_ready = 1; upd_ready = 1;
        step();
    endtask

    initial begin
        step();
        test_reset();
        test_load_word();
        test_store_byte();
        test_update_half();
        test_back_to_back();
        test_wrap();
        test_reserved_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
